fp_issue_ctrl: RTL and testbench

Front-end sequencer that sits directly upstream of the `fpu` top level. It accepts floating-point commands over a valid/ready handshake and buffers them in a small FIFO. Operands with special values (zero, infinity, NaN, denormal, exact cancellation) are resolved locally. Every other command is issued to `fpu` as a single start pulse, and the block waits for the done cycle. All results leave through one in-order valid/ready output port with status flags.

---
 rtl/fp_pkg.sv | 27 ++
 rtl/fp_cmd_fifo.sv | 36 +++
 rtl/fp_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fp_issue_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared constants, opcodes, flag positions and FSM encoding for the FP issue front end.
package fp_pkg;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  localparam int FLG_INVALID = 2;
  localparam int FLG_BYPASS  = 1;
  localparam int FLG_TIMEOUT = 0;

  localparam logic [2:0] FL_INV = 3'(1 << FLG_INVALID);
  localparam logic [2:0] FL_BYP = 3'(1 << FLG_BYPASS);
  localparam logic [2:0] FL_TMO = 3'(1 << FLG_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_RESULT
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } cmd_t;
endpackage

// File: rtl/fp_cmd_fifo.sv
// Command FIFO: DEPTH entries of {op, a, b}; extra pointer MSB separates full from empty.
module fp_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [65:0] din,
  output logic [65:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wp, rp;
  logic [65:0]  mem [DEPTH];

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)  wp <= wp + 1'b1;
      if (pop  && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fp_issue_ctrl.sv
// Sequencer in front of the fpu: buffers commands, resolves special operands locally,
// issues the rest with a one-cycle start pulse and returns all results in order.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [1:0]  in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic [2:0]  out_flags,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [1:0]  fpu_op,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_r
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  cmd_t          head, cmd_in;
  logic          full, empty, pop;
  logic [31:0]   ha, hb;
  logic [1:0]    hop;
  logic [CW-1:0] cnt;
  logic          tmo_hit;

  assign cmd_in = '{op: in_op, a: in_a, b: in_b};

  fp_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (in_valid),
    .pop  (pop),
    .din  (cmd_in),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign in_ready  = !full;
  assign out_valid = (state == S_RESULT);
  assign tmo_hit   = (cnt == TMO_MAX);

  // Operand classification; exponent 0 is treated as zero (denormals flushed).
  logic sa, sb, za, zb, ia, ib, na, nb;
  assign sa = ha[31];
  assign sb = hb[31];
  assign za = (ha[30:23] == 8'h00);
  assign zb = (hb[30:23] == 8'h00);
  assign ia = (ha[30:23] == 8'hFF) && (ha[22:0] == '0);
  assign ib = (hb[30:23] == 8'hFF) && (hb[22:0] == '0);
  assign na = (ha[30:23] == 8'hFF) && (ha[22:0] != '0);
  assign nb = (hb[30:23] == 8'hFF) && (hb[22:0] != '0);

  logic        sp;
  logic [31:0] sp_r;
  logic [2:0]  sp_f;

  always_comb begin
    sp   = 1'b1;
    sp_r = QNAN;
    sp_f = FL_INV | FL_BYP;
    if (hop == OP_ILL || na || nb) begin
      sp = 1'b1;
    end else if (hop == OP_MUL) begin
      if ((za && ib) || (ia && zb)) begin
        sp = 1'b1;
      end else if (ia || ib) begin
        sp_r = {sa ^ sb, 8'hFF, 23'h0};
        sp_f = FL_BYP;
      end else if (za || zb) begin
        sp_r = {sa ^ sb, 31'h0};
        sp_f = FL_BYP;
      end else begin
        sp = 1'b0;
      end
    end else begin
      sp_f = FL_BYP;
      if (ia && ib && (sa != sb)) begin
        sp_f = FL_INV | FL_BYP;
      end else if (ia) begin
        sp_r = ha;
      end else if (ib) begin
        sp_r = hb;
      end else if (za && zb) begin
        sp_r = {sa & sb, 31'h0};
      end else if (za) begin
        sp_r = hb;
      end else if (zb) begin
        sp_r = ha;
      end else if ((ha[30:0] == hb[30:0]) && (sa != sb)) begin
        sp_r = 32'h0;
      end else begin
        sp = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    fpu_start = 1'b0;
    case (state)
      S_IDLE:    if (!empty) begin pop = 1'b1; state_n = S_CHECK; end
      S_CHECK:   state_n = sp ? S_RESULT : S_ISSUE;
      S_ISSUE:   begin fpu_start = 1'b1; state_n = S_WAIT_LO; end
      // A done level still high from the previous op is ignored until it drops.
      S_WAIT_LO: if (!fpu_done) state_n = S_WAIT_HI;
                 else if (tmo_hit) state_n = S_RESULT;
      S_WAIT_HI: if (fpu_done || tmo_hit) state_n = S_RESULT;
      S_RESULT:  if (out_ready) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ha <= '0; hb <= '0; hop <= '0;
      out_r <= '0; out_flags <= '0;
      fpu_a <= '0; fpu_b <= '0; fpu_op <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          ha  <= head.a;
          hb  <= (head.op == OP_SUB) ? {~head.b[31], head.b[30:0]} : head.b;
          hop <= (head.op == OP_SUB) ? OP_ADD : head.op;
        end
        S_CHECK: if (sp) begin
          out_r     <= sp_r;
          out_flags <= sp_f;
        end else begin
          fpu_a  <= ha;
          fpu_b  <= hb;
          fpu_op <= hop;
        end
        S_ISSUE: cnt <= '0;
        S_WAIT_LO: if (fpu_done && tmo_hit) begin
          out_r <= QNAN; out_flags <= FL_TMO;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_WAIT_HI: if (fpu_done) begin
          out_r <= fpu_r; out_flags <= '0;
        end else if (tmo_hit) begin
          out_r <= QNAN; out_flags <= FL_TMO;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl with a behavioural fpu stub (fixed latency, optional stuck done).
module tb_fp_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [31:0] QN = 32'h7FC00000;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_r;
  logic [2:0]  out_flags;
  logic [31:0] fpu_a, fpu_b, fpu_r;
  logic [1:0]  fpu_op;
  logic        fpu_start, fpu_done;

  always #5 clk = ~clk;

  fp_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_flags(out_flags),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_start(fpu_start),
    .fpu_done(fpu_done), .fpu_r(fpu_r)
  );

  // fpu stub: single-precision values routed through real arithmetic (normal operands only).
  function automatic real s2r(input logic [31:0] a);
    logic [63:0] d;
    d = {a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == '0) return {d[63], 31'h0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  int   stub_lat = 3, stub_cnt = 0;
  bit   stub_stuck = 1'b0;
  logic stub_done = 1'b0;
  logic [31:0] stub_r = '0;
  assign fpu_done = stub_stuck | stub_done;
  assign fpu_r    = stub_r;

  always @(posedge clk) begin
    if (rst) begin
      stub_done <= 1'b0; stub_cnt <= 0;
    end else if (fpu_start) begin
      stub_done <= 1'b0;
      stub_cnt  <= stub_lat;
      stub_r    <= r2s(fpu_op == 2'b10 ? s2r(fpu_a) * s2r(fpu_b) : s2r(fpu_a) + s2r(fpu_b));
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
  end

  int checks = 0, errors = 0, npop = 0, nstart = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] r; logic [2:0] f; } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (fpu_start) nstart++;
    if (!rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: got %h with empty scoreboard", out_r);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_r", out_r, e.r);
        chk("out_flags", 32'(out_flags), 32'(e.f));
      end
      npop++;
    end
  end

  task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [2:0] f);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 300) begin
        checks++; errors++;
        $display("FAIL push_timeout: in_ready stuck at 0");
        break;
      end
    end
    @(posedge clk);
    sbq.push_back('{r: r, f: f});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sbq.size() != 0 && n < budget) begin @(posedge clk); n++; end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] op; logic [31:0] a, b, r; logic [2:0] f;
    bit iss; logic [31:0] fb; logic [1:0] fop;
  } vec_t;
  vec_t v[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, np0, n;
    v[0]  = '{2'b00, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 1, 32'h40000000, 2'b00};
    v[1]  = '{2'b01, 32'h40400000, 32'h3F800000, 32'h40000000, 3'b000, 1, 32'hBF800000, 2'b00};
    v[2]  = '{2'b10, 32'h7F800000, 32'h00000000, QN,           3'b110, 0, 32'h0,        2'b00};
    v[3]  = '{2'b00, 32'h00000000, 32'hC0000000, 32'hC0000000, 3'b010, 0, 32'h0,        2'b00};
    v[4]  = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b010, 0, 32'h0,        2'b00};
    v[5]  = '{2'b11, 32'h3F800000, 32'h40000000, QN,           3'b110, 0, 32'h0,        2'b00};
    v[6]  = '{2'b10, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, 1, 32'h40400000, 2'b10};
    v[7]  = '{2'b00, 32'hFF800000, 32'h7F800000, QN,           3'b110, 0, 32'h0,        2'b00};
    v[8]  = '{2'b10, 32'h80000000, 32'h3F800000, 32'h80000000, 3'b010, 0, 32'h0,        2'b00};
    v[9]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h80000000, 3'b010, 0, 32'h0,        2'b00};
    v[10] = '{2'b00, 32'h7FC00001, 32'h3F800000, QN,           3'b110, 0, 32'h0,        2'b00};
    v[11] = '{2'b10, 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b010, 0, 32'h0,        2'b00};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_r", out_r, 0);
    chk("rst_fpu_start", 32'(fpu_start), 0);
    chk("rst_fpu_a", fpu_a, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (v[i]) begin
      s0 = nstart;
      push(v[i].op, v[i].a, v[i].b, v[i].r, v[i].f);
      if (!v[i].iss) begin
        chk("byp_lat_t0", 32'(out_valid), 0);
        @(posedge clk); #1 chk("byp_lat_t1", 32'(out_valid), 0);
        @(posedge clk); #1 chk("byp_lat_t2", 32'(out_valid), 1);
      end
      drain(100);
      chk("start_count", 32'(nstart - s0), v[i].iss ? 1 : 0);
      if (v[i].iss) begin
        chk("fpu_b", fpu_b, v[i].fb);
        chk("fpu_op", 32'(fpu_op), 32'(v[i].fop));
      end
    end

    // Backpressure: 1 held + DEPTH queued, then the next push stalls
    out_ready = 1'b0;
    np0 = npop;
    for (int i = 0; i < 5; i++)
      push(2'b00, 32'h0, 32'h41000000 + 32'(i), 32'h41000000 + 32'(i), 3'b010);
    repeat (2) @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_r_stable", out_r, 32'h41000000);
    fork
      push(2'b00, 32'h0, 32'h41000005, 32'h41000005, 3'b010);
      begin repeat (4) @(posedge clk); #1 out_ready = 1'b1; end
    join
    drain(200);
    chk("bp_count", 32'(npop - np0), 6);

    // Timeout with done stuck high
    stub_stuck = 1'b1;
    push(2'b00, 32'h3F800000, 32'h40000000, QN, 3'b001);
    n = 0;
    while (!fpu_start && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 500);
    chk("tmo_cycles", 32'(n), TIMEOUT + 1);
    drain(100);
    stub_stuck = 1'b0;
    push(2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
    drain(100);

    // Reset while waiting on fpu with two commands queued
    stub_lat = 30;
    push(2'b00, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    push(2'b00, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
    push(2'b10, 32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    rst = 1'b0;
    sbq.delete();
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_out_r", out_r, 0);
    chk("mid_rst_flags", 32'(out_flags), 0);
    chk("mid_rst_fpu_a", fpu_a, 0);
    chk("mid_rst_fpu_b", fpu_b, 0);
    chk("mid_rst_fpu_op", 32'(fpu_op), 0);
    s0 = nstart;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_empty_valid", 32'(out_valid), 0);
    chk("mid_rst_empty_start", 32'(nstart - s0), 0);
    stub_lat = 3;
    push(2'b00, 32'h3F800000, 32'h40400000, 32'h40800000, 3'b000);
    drain(100);
    chk("mid_rst_fresh_start", 32'(nstart - s0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
